// File: rtl/line_ctrl_pkg.sv
// Shared types and default geometry for the tile line-buffer controller.
package line_ctrl_pkg;

  typedef enum logic [1:0] {
    PREFILL0   = 2'd0,
    PREFILL1   = 2'd1,
    WAIT_FRAME = 2'd2,
    DISPLAY    = 2'd3
  } line_ctrl_state_t;

  localparam int DEF_WIDTH_PX    = 640;
  localparam int DEF_HEIGHT_PX   = 480;
  localparam int DEF_TILE_WIDTH  = 4;
  localparam int DEF_TILE_HEIGHT = 4;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; only exists when LINE_CTRL_UNDERRUN_CNT_EN is defined.
`ifdef LINE_CTRL_UNDERRUN_CNT_EN
module sat_counter
  import line_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/line_ctrl.sv
// Ping-pong tile line-buffer controller: prefill, frame alignment, row swaps, underrun.
// Optional underrun counter enabled by defining LINE_CTRL_UNDERRUN_CNT_EN.
module line_ctrl
  import line_ctrl_pkg::*;
#(
  parameter int WIDTH_PX         = DEF_WIDTH_PX,
  parameter int HEIGHT_PX        = DEF_HEIGHT_PX,
  parameter int TILE_WIDTH       = DEF_TILE_WIDTH,
  parameter int TILE_HEIGHT      = DEF_TILE_HEIGHT,
  parameter int LBUFF_ADDR_WIDTH = $clog2(WIDTH_PX / TILE_WIDTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        disp_active_i,
  input  logic [9:0]                  disp_x_i,
  input  logic [9:0]                  disp_y_i,
  input  logic [1:0]                  buff_fill_done_i,
  output logic [1:0]                  buff_fill_req_o,
  output logic [1:0]                  buff_sel_o,
  output logic [LBUFF_ADDR_WIDTH-1:0] disp_pxl_id_o,
  output logic                        underrun_o,
  output logic [15:0]                 underrun_cnt_o
);

  localparam logic [9:0] X_LAST   = 10'(WIDTH_PX - 1);
  localparam logic [9:0] Y_LIMIT  = 10'(HEIGHT_PX);
  localparam logic [9:0] TILE_W   = 10'(TILE_WIDTH);
  localparam logic [9:0] TILE_H   = 10'(TILE_HEIGHT);
  localparam logic [9:0] ROW_LAST = 10'(TILE_HEIGHT - 1);

  line_ctrl_state_t            state_q, state_d;
  logic [1:0]                  sel_q, sel_d;
  logic [1:0]                  req_q, req_d;
  logic [1:0]                  pend_q, pend_d;
  logic [1:0]                  rdy_q, rdy_d;
  logic [LBUFF_ADDR_WIDTH-1:0] pxl_q, pxl_d;
  logic                        under_q, under_d;
  logic [1:0]                  done_ok;
  logic                        swap_pt;
  logic                        frame_start;

  // Done pulses only count for a buffer that actually has a fill outstanding.
  assign done_ok     = buff_fill_done_i & pend_q;
  assign swap_pt     = disp_active_i && (disp_x_i == X_LAST) && (disp_y_i < Y_LIMIT)
                       && ((disp_y_i % TILE_H) == ROW_LAST);
  assign frame_start = disp_active_i && (disp_x_i == '0) && (disp_y_i == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    req_d   = 2'b00;
    pend_d  = pend_q & ~done_ok;
    rdy_d   = rdy_q | done_ok;
    pxl_d   = '0;
    under_d = 1'b0;

    unique case (state_q)
      PREFILL0: begin
        if (done_ok[0]) begin
          state_d   = PREFILL1;
          req_d     = 2'b10;
          pend_d[1] = 1'b1;
          rdy_d[1]  = 1'b0;
        end else if (!pend_q[0]) begin
          req_d     = 2'b01;
          pend_d[0] = 1'b1;
          rdy_d[0]  = 1'b0;
        end
      end
      PREFILL1: begin
        if (done_ok[1]) begin
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        // Selection is registered so it lines up with the registered tile index.
        if (frame_start) begin
          state_d = DISPLAY;
          sel_d   = 2'b01;
        end
      end
      DISPLAY: begin
        if (disp_active_i) begin
          pxl_d = LBUFF_ADDR_WIDTH'(disp_x_i / TILE_W);
        end
        // rdy_d already folds in a done arriving on the swap cycle itself.
        if (swap_pt) begin
          if (|(rdy_d & ~sel_q)) begin
            sel_d  = ~sel_q;
            req_d  = sel_q;
            pend_d = pend_d | sel_q;
            rdy_d  = rdy_d & ~sel_q;
          end else begin
            under_d = 1'b1;
          end
        end
      end
      default: state_d = PREFILL0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PREFILL0;
      sel_q   <= 2'b00;
      req_q   <= 2'b00;
      pend_q  <= 2'b00;
      rdy_q   <= 2'b00;
      pxl_q   <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
      pxl_q   <= pxl_d;
      under_q <= under_d;
    end
  end

  assign buff_fill_req_o = req_q;
  assign buff_sel_o      = sel_q;
  assign disp_pxl_id_o   = pxl_q;
  assign underrun_o      = under_q;

`ifdef LINE_CTRL_UNDERRUN_CNT_EN
  sat_counter #(.W(16)) u_underrun_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (under_d),
    .cnt_o (underrun_cnt_o)
  );
`else
  assign underrun_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_line_ctrl.sv
// Bench for line_ctrl: directed table, corner sequences, randomized run vs reference model.
module tb_line_ctrl;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int TW = 4;
  localparam int TH = 4;
  localparam int AW = $clog2(W / TW);

`ifdef LINE_CTRL_UNDERRUN_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          act = 1'b0;
  logic [9:0]    x = '0;
  logic [9:0]    y = '0;
  logic [1:0]    done = '0;
  logic [1:0]    req;
  logic [1:0]    sel;
  logic [AW-1:0] pxl;
  logic          und;
  logic [15:0]   cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  line_ctrl #(
    .WIDTH_PX(W), .HEIGHT_PX(H), .TILE_WIDTH(TW), .TILE_HEIGHT(TH), .LBUFF_ADDR_WIDTH(AW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .disp_active_i    (act),
    .disp_x_i         (x),
    .disp_y_i         (y),
    .buff_fill_done_i (done),
    .buff_fill_req_o  (req),
    .buff_sel_o       (sel),
    .disp_pxl_id_o    (pxl),
    .underrun_o       (und),
    .underrun_cnt_o   (cnt)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input int er, input int es, input int ep,
                         input int eu, input int ec);
    chk({nm, ".req"}, 32'(req), er);
    chk({nm, ".sel"}, 32'(sel), es);
    chk({nm, ".pxl"}, 32'(pxl), ep);
    chk({nm, ".und"}, 32'(und), eu);
    chk({nm, ".cnt"}, 32'(cnt), ec);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input bit a, input int xx, input int yy,
                     input bit [1:0] d, input int er, input int es, input int ep, input int eu);
    act  = a;
    x    = 10'(xx);
    y    = 10'(yy);
    done = d;
    tick();
    chk({nm, ".req"}, 32'(req), er);
    chk({nm, ".sel"}, 32'(sel), es);
    chk({nm, ".pxl"}, 32'(pxl), ep);
    chk({nm, ".und"}, 32'(und), eu);
  endtask

  // Reference model: stage of bring-up, which buffer is on screen, and per-buffer fill bookkeeping.
  int       m_mode;
  int       m_shown;
  bit [1:0] m_filled;
  bit [1:0] m_asked;
  int       m_cnt;
  int       e_req, e_sel, e_pxl, e_und;

  task automatic m_reset();
    m_mode = 0; m_shown = 0; m_filled = '0; m_asked = '0; m_cnt = 0;
    e_req = 0; e_sel = 0; e_pxl = 0; e_und = 0;
  endtask

  task automatic m_ask(input int b);
    e_req       = 1 << b;
    m_asked[b]  = 1'b1;
    m_filled[b] = 1'b0;
  endtask

  task automatic m_clock(input bit a, input int xx, input int yy, input bit [1:0] d);
    int other;
    e_req = 0; e_und = 0; e_pxl = 0;
    for (int i = 0; i < 2; i++) begin
      if (d[i] && m_asked[i]) begin
        m_filled[i] = 1'b1;
        m_asked[i]  = 1'b0;
      end
    end
    case (m_mode)
      0: if (d[0] && !m_asked[0] && m_filled[0]) begin
           m_mode = 1;
           m_ask(1);
         end else if (!m_asked[0]) begin
           m_ask(0);
         end
      1: if (m_filled[1] && !m_asked[1] && d[1]) m_mode = 2;
      2: if (a && xx == 0 && yy == 0) begin
           m_mode = 3;
           m_shown = 0;
         end
      default: begin
        if (a) e_pxl = xx / TW;
        if (a && xx == W - 1 && yy < H && (yy % TH) == TH - 1) begin
          other = 1 - m_shown;
          if (m_filled[other]) begin
            m_ask(m_shown);
            m_shown = other;
          end else begin
            e_und = 1;
            if (m_cnt < 65535) m_cnt++;
          end
        end
      end
    endcase
    e_sel = (m_mode == 3) ? (1 << m_shown) : 0;
  endtask

  typedef struct {
    bit       r;
    bit       a;
    int       xx;
    int       yy;
    bit [1:0] d;
    int       n;
    int       er;
    int       es;
    int       ep;
    int       eu;
    int       ec;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit a, input int xx, input int yy,
                              input bit [1:0] d, input int n, input int er, input int es,
                              input int ep, input int eu, input int ec);
    vec_t v;
    v.r = r; v.a = a; v.xx = xx; v.yy = yy; v.d = d; v.n = n;
    v.er = er; v.es = es; v.ep = ep; v.eu = eu; v.ec = ec;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    int   cc;
    cc = CNT_ON ? 1 : 0;

    tbl.push_back(mk(1, 0,   0,  0, 2'b00,  3, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 2'b00,  1, 1, 0,   0, 0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 2'b00, 99, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 2'b01,  1, 2, 0,   0, 0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 2'b00, 99, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 2'b10,  1, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 1,   5,  3, 2'b00,  5, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 1,   0,  0, 2'b00,  1, 0, 1,   0, 0, 0));
    tbl.push_back(mk(0, 1,  13,  0, 2'b00,  1, 0, 1,   3, 0, 0));
    tbl.push_back(mk(0, 0,  13,  0, 2'b00,  1, 0, 1,   0, 0, 0));
    tbl.push_back(mk(0, 1, 639,  3, 2'b00,  1, 1, 2, 159, 0, 0));
    tbl.push_back(mk(0, 1, 100,  4, 2'b00,  1, 0, 2,  25, 0, 0));
    tbl.push_back(mk(0, 1, 639,  7, 2'b00,  1, 0, 2, 159, 1, cc));
    tbl.push_back(mk(0, 1,   0,  8, 2'b00,  1, 0, 2,   0, 0, cc));
    tbl.push_back(mk(0, 1, 639, 11, 2'b01,  1, 2, 1, 159, 0, cc));
    tbl.push_back(mk(0, 1, 639, 15, 2'b00,  1, 0, 1, 159, 1, 2 * cc));

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst  = tbl[i].r;
      act  = tbl[i].a;
      x    = 10'(tbl[i].xx);
      y    = 10'(tbl[i].yy);
      done = tbl[i].d;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        chk_out($sformatf("tbl%0d", i), tbl[i].er, tbl[i].es, tbl[i].ep, tbl[i].eu, tbl[i].ec);
      end
    end

    // Reset in DISPLAY with buffer 1 still being filled; outputs must clear without a clock edge.
    act = 1'b1; x = 10'd20; y = 10'd16; done = 2'b00;
    rst = 1'b1;
    #2;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    tick();
    chk_out("rst_hold", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("rel_first", 0, 0, 0, 2'b10, 1, 0, 0, 0);
    cyc("stale_done", 0, 0, 0, 2'b10, 0, 0, 0, 0);
    cyc("pf0_done", 0, 0, 0, 2'b01, 2, 0, 0, 0);
    cyc("pf1_done", 0, 0, 0, 2'b10, 0, 0, 0, 0);
    cyc("frame0", 1, 0, 0, 2'b00, 0, 1, 0, 0);
    cyc("swap_a", 1, 639, 3, 2'b00, 1, 2, 159, 0);
    cyc("coinc0", 1, 639, 7, 2'b01, 2, 1, 159, 0);
    cyc("coinc1", 1, 639, 11, 2'b10, 1, 2, 159, 0);
    cyc("last_row", 1, 639, 479, 2'b01, 2, 1, 159, 0);

    // Randomized run against the reference model.
    rst = 1'b1;
    m_reset();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick();
        m_reset();
        chk_out("rnd_rst", e_req, e_sel, e_pxl, e_und, 0);
        rst = 1'b0;
      end else begin
        act = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 3))
          0: begin x = 10'd0; y = 10'd0; end
          1: begin x = 10'(W - 1); y = 10'($urandom_range(0, H / TH - 1) * TH + TH - 1); end
          default: begin x = 10'($urandom_range(0, W - 1)); y = 10'($urandom_range(0, H - 1)); end
        endcase
        done = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        tick();
        m_clock(act, int'(x), int'(y), done);
        chk_out("rnd", e_req, e_sel, e_pxl, e_und, CNT_ON ? m_cnt : 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
